// File: rtl/apu_sample_fetch.sv
// APU sample fetcher: bursts 64-bit words from a ring buffer in memory into an
// 8-word FIFO and unpacks them into 16-bit stereo frames on each sample request.
module apu_sample_fetch #(
  parameter int BUF_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] control,
  input  logic        control_valid,
  output logic [28:0] mem_addr,
  output logic        mem_read_en,
  input  logic [63:0] mem_data,
  input  logic        mem_ack,
  input  logic        sample_req,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  output logic [15:0] underflow_cnt
);

  localparam int OFF_W = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic               enable_q, enable_d;
  logic [28:0]        base_q, base_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic               pend_vld_q, pend_vld_d;
  logic [31:0]        pend_q, pend_d;
  logic [2:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]         wr_ptr_q, wr_ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               half_q, half_d;
  logic [15:0]        sample_l_q, sample_l_d;
  logic [15:0]        sample_r_q, sample_r_d;
  logic               sample_valid_q, sample_valid_d;
  logic [15:0]        underflow_q, underflow_d;
  logic [63:0]        fifo_q [8];

  logic               push, pop, flush, apply;
  logic [31:0]        apply_word;
  logic [31:0]        head_half;

  assign mem_read_en   = (state_q == REQ);
  assign mem_addr      = base_q + 29'(offset_q);
  assign sample_l      = sample_l_q;
  assign sample_r      = sample_r_q;
  assign sample_valid  = sample_valid_q;
  assign underflow_cnt = underflow_q;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    enable_d       = enable_q;
    base_d         = base_q;
    offset_d       = offset_q;
    pend_vld_d     = pend_vld_q;
    pend_d         = pend_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    cnt_d          = cnt_q;
    half_d         = half_q;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = 1'b0;
    underflow_d    = underflow_q;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;
    apply          = 1'b0;
    apply_word     = pend_q;
    head_half      = half_q ? fifo_q[rd_ptr_q][63:32] : fifo_q[rd_ptr_q][31:0];

    case (state_q)
      IDLE: begin
        if (control_valid) begin
          apply      = 1'b1;
          apply_word = control;
        end else if (enable_q && cnt_q <= 4'd4) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = DATA;
        beat_d  = 2'd0;
        if (control_valid) begin
          pend_vld_d = 1'b1;
          pend_d     = control;
          if (!control[31]) begin
            enable_d = 1'b0;
            state_d  = DRAIN;
          end
        end
      end
      default: begin
        // DATA and DRAIN both count beats; only DATA keeps them
        if (mem_ack) begin
          beat_d = beat_q + 2'd1;
          push   = (state_q == DATA);
        end
        if (mem_ack && beat_q == 2'd3) begin
          state_d = IDLE;
          if (state_q == DATA) offset_d = offset_q + OFF_W'(4);
          else                 flush    = 1'b1;
          if (control_valid || pend_vld_q) begin
            apply      = 1'b1;
            apply_word = control_valid ? control : pend_q;
          end
        end else if (control_valid) begin
          pend_vld_d = 1'b1;
          pend_d     = control;
          if (!control[31]) begin
            enable_d = 1'b0;
            state_d  = DRAIN;
          end
        end
      end
    endcase

    // Both enabling and disabling start from an empty FIFO
    if (apply) begin
      pend_vld_d = 1'b0;
      enable_d   = apply_word[31];
      flush      = 1'b1;
      if (apply_word[31]) begin
        base_d   = {apply_word[28:2], 2'b00};
        offset_d = '0;
      end
    end

    if (sample_req) begin
      sample_valid_d = 1'b1;
      if (cnt_q != 4'd0) begin
        sample_l_d = head_half[15:0];
        sample_r_d = head_half[31:16];
        half_d     = ~half_q;
        pop        = half_q;
      end else begin
        sample_l_d = 16'h0000;
        sample_r_d = 16'h0000;
        if (enable_q && underflow_q != 16'hFFFF) underflow_d = underflow_q + 16'd1;
      end
    end

    if (control_valid && control[31]) underflow_d = 16'h0000;

    if (flush) begin
      rd_ptr_d = 3'd0;
      wr_ptr_d = 3'd0;
      cnt_d    = 4'd0;
      half_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
      cnt_d = cnt_q + {3'b000, push} - {3'b000, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      enable_q       <= 1'b0;
      base_q         <= '0;
      offset_q       <= '0;
      pend_vld_q     <= 1'b0;
      pend_q         <= '0;
      rd_ptr_q       <= 3'd0;
      wr_ptr_q       <= 3'd0;
      cnt_q          <= 4'd0;
      half_q         <= 1'b0;
      sample_l_q     <= 16'h0000;
      sample_r_q     <= 16'h0000;
      sample_valid_q <= 1'b0;
      underflow_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      enable_q       <= enable_d;
      base_q         <= base_d;
      offset_q       <= offset_d;
      pend_vld_q     <= pend_vld_d;
      pend_q         <= pend_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      half_q         <= half_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      underflow_q    <= underflow_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_data;
  end

endmodule

// File: tb/tb_apu_sample_fetch.sv
// Directed bench for apu_sample_fetch with an 8-word ring; expected frames are
// queued as beats are driven and compared as sample_valid frames come out.
module tb_apu_sample_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] control;
  logic        control_valid;
  logic [28:0] mem_addr;
  logic        mem_read_en;
  logic [63:0] mem_data;
  logic        mem_ack;
  logic        sample_req;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  apu_sample_fetch #(.BUF_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .control(control), .control_valid(control_valid),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_data(mem_data),
    .mem_ack(mem_ack), .sample_req(sample_req), .sample_l(sample_l),
    .sample_r(sample_r), .sample_valid(sample_valid), .underflow_cnt(underflow_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ctrl(input logic [31:0] w);
    control = w;
    control_valid = 1'b1;
    tick();
    control_valid = 1'b0;
  endtask

  // Waits for the read command, checks its address and single-cycle width
  task automatic wait_req(input string tag, input logic [28:0] exp_addr);
    int n = 0;
    while (mem_read_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(mem_read_en), 32'h1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    tick();
    chk({tag, "_pulse"}, 32'(mem_read_en), 32'h0);
  endtask

  task automatic beat(input logic [63:0] d, input bit keep);
    mem_data = d;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    if (keep) begin
      sb.push_back(d[31:0]);
      sb.push_back(d[63:32]);
    end
  endtask

  task automatic burst(input bit keep);
    for (int i = 0; i < 4; i++) beat({$urandom, $urandom}, keep);
  endtask

  task automatic sample(input string tag, input bit expect_empty);
    logic [31:0] exp;
    if (expect_empty) sb.push_back(32'h0);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_valid"}, 32'(sample_valid), 32'h1);
    chk({tag, "_frame"}, {sample_r, sample_l}, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_read_en), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_frame"}, {sample_r, sample_l}, 32'h0);
    chk({tag, "_svalid"}, 32'(sample_valid), 32'h0);
    chk({tag, "_uflow"}, 32'(underflow_cnt), 32'h0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (mem_read_en) seen = 1'b1;
      tick();
    end
    chk(tag, 32'(seen), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    control = '0;
    control_valid = 1'b0;
    mem_data = '0;
    mem_ack = 1'b0;
    sample_req = 1'b0;
    #25;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // disabled request: zero frame, no underflow count
    sample("dis_sample", 1'b1);
    chk("dis_uflow", 32'(underflow_cnt), 32'h0);

    // start; low base bits are forced to zero
    do_ctrl(32'h8000_1003);
    wait_req("req0", 29'h1000);
    beat(64'h4444_3333_2222_1111, 1'b1);
    beat(64'h8888_7777_6666_5555, 1'b1);
    beat(64'hCCCC_BBBB_AAAA_9999, 1'b1);
    beat(64'h0F0F_E0E0_D0D0_C0C0, 1'b1);
    wait_req("req1", 29'h1004);
    burst(1'b1);
    expect_quiet("full_no_req", 10);

    // unpack order and hold between requests
    sample("unpk0", 1'b0);
    chk("unpk0_l", 32'(sample_l), 32'h1111);
    sample("unpk1", 1'b0);
    chk("unpk1_r", 32'(sample_r), 32'h4444);
    tick(); tick(); tick();
    chk("hold_l", 32'(sample_l), 32'h3333);
    chk("hold_valid", 32'(sample_valid), 32'h0);
    for (int i = 0; i < 6; i++) sample("drain8", 1'b0);
    wait_req("wrap8", 29'h1000);

    // disable after beat 1: rest discarded, FIFO flushed, no new requests
    beat({$urandom, $urandom}, 1'b0);
    do_ctrl(32'h0000_0000);
    for (int i = 0; i < 3; i++) beat({$urandom, $urandom}, 1'b0);
    sb.delete();
    tick();
    sample("after_dis", 1'b1);
    chk("after_dis_uflow", 32'(underflow_cnt), 32'h0);
    expect_quiet("dis_no_req", 20);

    // underflow while enabled and waiting on memory
    do_ctrl(32'h8000_0100);
    wait_req("uf_req", 29'h100);
    for (int i = 0; i < 3; i++) sample("uflow", 1'b1);
    chk("uflow_cnt", 32'(underflow_cnt), 32'h3);

    // finish burst, then ring wrap back to base
    burst(1'b1);
    wait_req("ring1", 29'h104);
    burst(1'b1);
    for (int i = 0; i < 8; i++) sample("ring_s", 1'b0);
    wait_req("ring2", 29'h100);

    // reset between beats 2 and 3
    beat({$urandom, $urandom}, 1'b1);
    beat({$urandom, $urandom}, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    sb.delete();
    tick();
    rst_n = 1'b1;
    beat({$urandom, $urandom}, 1'b0);
    beat({$urandom, $urandom}, 1'b0);
    sample("post_rst", 1'b1);
    chk("post_rst_uflow", 32'(underflow_cnt), 32'h0);
    expect_quiet("post_rst_no_req", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
